// File: rtl/audio_nios_i2c_pkg.sv
// Shared types and constants for the WM8731-style I2C control-port target.
package audio_nios_i2c_pkg;

  localparam int          ADDR_W       = 7;
  localparam int          DATA_W       = 9;
  localparam logic [6:0]  DEF_DEV_ADDR = 7'h1A;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ACK_A,
    ST_BYTE1,
    ST_ACK_1,
    ST_BYTE2,
    ST_ACK_2,
    ST_EXTRA,
    ST_IGNORE
  } state_e;

  // A transfer is "ours" from the address ACK until it is rejected or stopped.
  function automatic logic is_busy(input state_e s);
    return (s == ST_ACK_A) || (s == ST_BYTE1) || (s == ST_ACK_1) ||
           (s == ST_BYTE2) || (s == ST_ACK_2) || (s == ST_EXTRA);
  endfunction

endpackage

// File: rtl/audio_nios_i2c_line_filter.sv
// Synchroniser, glitch filter and single-cycle edge pulses for one bus line.
// The filtered level and its edge pulses update on the same clk edge, so
// pin-to-pulse latency is SYNC_STAGES + FILTER_LEN clocks.
module audio_nios_i2c_line_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   level_q;
  logic                   rise_q;
  logic                   fall_q;
  logic                   sample;

  assign sample = sync_q[SYNC_STAGES-1];

  // Synchronise the asynchronous pin; idle bus level is high.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '1;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
  end

  // Change the filtered level only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      level_q <= 1'b1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      if (sample == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
        cnt_q   <= '0;
        level_q <= sample;
        rise_q  <= sample;
        fall_q  <= ~sample;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/audio_nios_i2c_target.sv
// I2C target emulating the WM8731 control port: ACKs {DEV_ADDR,W}, accepts
// two-byte register writes and emits one reg_wr strobe per completed write.
module audio_nios_i2c_target
  import audio_nios_i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = DEF_DEV_ADDR,
  parameter int         SYNC_STAGES = 2,
  parameter int         FILTER_LEN  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scl_in,
  input  logic              sda_in,
  output logic              sda_oe,
  output logic              reg_wr,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_data,
  output logic              busy,
  output logic              nack_err
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  audio_nios_i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_scl_filt (
    .clk(clk), .reset(reset), .pin_i(scl_in),
    .level_o(scl_lvl), .rise_o(scl_rise), .fall_o(scl_fall)
  );

  audio_nios_i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_sda_filt (
    .clk(clk), .reset(reset), .pin_i(sda_in),
    .level_o(sda_lvl), .rise_o(sda_rise), .fall_o(sda_fall)
  );

  state_e              state_q, state_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [7:0]          shift_q, shift_d;
  logic [ADDR_W-1:0]   hold_addr_q, hold_addr_d;
  logic                hold_d8_q, hold_d8_d;
  logic                sda_oe_q, sda_oe_d;
  logic                reg_wr_q, reg_wr_d;
  logic [ADDR_W-1:0]   reg_addr_q, reg_addr_d;
  logic [DATA_W-1:0]   reg_data_q, reg_data_d;
  logic                nack_err_q, nack_err_d;

  // SCL level before this cycle's edge, so a coincident SDA edge is judged
  // against the SCL state it actually happened under.
  logic scl_high_prior;
  logic start_det, stop_det;
  logic [7:0] byte_val;

  assign scl_high_prior = (scl_lvl & ~scl_rise) | scl_fall;
  assign start_det      = sda_fall & scl_high_prior;
  assign stop_det       = sda_rise & scl_high_prior;
  assign byte_val       = {shift_q[6:0], sda_lvl};

  // Next-state, shifting and ACK/commit decisions.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    hold_addr_d = hold_addr_q;
    hold_d8_d   = hold_d8_q;
    sda_oe_d    = sda_oe_q;
    reg_wr_d    = 1'b0;
    reg_addr_d  = reg_addr_q;
    reg_data_d  = reg_data_q;
    nack_err_d  = 1'b0;

    if (start_det) begin
      state_d   = ST_ADDR;
      bit_cnt_d = 3'd0;
      sda_oe_d  = 1'b0;
    end else if (stop_det) begin
      state_d  = ST_IDLE;
      sda_oe_d = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR, ST_BYTE1, ST_BYTE2, ST_EXTRA: begin
          if (scl_rise) begin
            shift_d   = byte_val;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              case (state_q)
                ST_ADDR: begin
                  if (byte_val == {DEV_ADDR, 1'b0}) begin
                    state_d = ST_ACK_A;
                  end else begin
                    state_d    = ST_IGNORE;
                    nack_err_d = (byte_val[7:1] == DEV_ADDR);
                  end
                end
                ST_BYTE1: begin
                  hold_addr_d = byte_val[7:1];
                  hold_d8_d   = byte_val[0];
                  state_d     = ST_ACK_1;
                end
                ST_BYTE2: state_d = ST_ACK_2;
                default: begin
                  nack_err_d = 1'b1;
                  state_d    = ST_IGNORE;
                end
              endcase
            end
          end
        end
        ST_ACK_A, ST_ACK_1, ST_ACK_2: begin
          // First SCL fall opens the ACK slot, the second one closes it.
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              case (state_q)
                ST_ACK_A: state_d = ST_BYTE1;
                ST_ACK_1: state_d = ST_BYTE2;
                default: begin
                  state_d    = ST_EXTRA;
                  reg_wr_d   = 1'b1;
                  reg_addr_d = hold_addr_q;
                  reg_data_d = {hold_d8_q, shift_q};
                end
              endcase
            end
          end
        end
        ST_IGNORE: sda_oe_d = 1'b0;
        default: ;
      endcase
    end
  end

  // State and output registers; reset releases SDA immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      hold_addr_q <= '0;
      hold_d8_q   <= 1'b0;
      sda_oe_q    <= 1'b0;
      reg_wr_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_data_q  <= '0;
      nack_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      hold_addr_q <= hold_addr_d;
      hold_d8_q   <= hold_d8_d;
      sda_oe_q    <= sda_oe_d;
      reg_wr_q    <= reg_wr_d;
      reg_addr_q  <= reg_addr_d;
      reg_data_q  <= reg_data_d;
      nack_err_q  <= nack_err_d;
    end
  end

  assign sda_oe   = sda_oe_q;
  assign reg_wr   = reg_wr_q;
  assign reg_addr = reg_addr_q;
  assign reg_data = reg_data_q;
  assign nack_err = nack_err_q;
  assign busy     = is_busy(state_q);

endmodule
